uart_mmio: RTL and testbench

- Memory-mapped bus responder for the CPU data port. Sits between the core's dataaddr/writedata/memwriteM/readdata bus and the uart serial engine.
- Write side: buffers outgoing bytes in a TX FIFO and drives the engine's valid/ack transmit handshake.
- Read side: captures received bytes into an RX FIFO and exposes data, status and control registers at a base address.
- Drives a level interrupt for ext_irq_r.

---
 rtl/uart_mmio_pkg.sv | 46 ++++
 rtl/uart_mmio_if.sv | 45 ++++
 rtl/uart_sync_fifo.sv | 55 +++++
 rtl/uart_mmio.sv | 157 +++++++++++++++
 tb/tb_uart_mmio.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the UART memory-mapped responder: register
// indices inside the 16-byte window, STATUS/CTRL bit positions and a
// helper that assembles the STATUS word.
package uart_mmio_pkg;

    // Word index within the register window (dataaddr[3:2]).
    typedef enum logic [1:0] {
        UART_REG_DATA   = 2'd0,
        UART_REG_STATUS = 2'd1,
        UART_REG_CTRL   = 2'd2,
        UART_REG_RSVD   = 2'd3
    } uart_reg_e;

    // STATUS bit positions.
    localparam int STAT_RX_VALID     = 0;
    localparam int STAT_TX_FULL      = 1;
    localparam int STAT_TX_EMPTY     = 2;
    localparam int STAT_RX_OVF       = 3;
    localparam int STAT_TX_OVF       = 4;
    localparam int STAT_RX_COUNT_LSB = 8;

    // CTRL bit positions.
    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    // Assemble the STATUS read word from its individual fields.
    function automatic logic [31:0] pack_status(
        input logic [7:0] rx_count,
        input logic       tx_ovf,
        input logic       rx_ovf,
        input logic       tx_empty,
        input logic       tx_full,
        input logic       rx_valid
    );
        logic [31:0] word;
        word                                        = '0;
        word[STAT_RX_COUNT_LSB +: 8]                = rx_count;
        word[STAT_TX_OVF]                           = tx_ovf;
        word[STAT_RX_OVF]                           = rx_ovf;
        word[STAT_TX_EMPTY]                         = tx_empty;
        word[STAT_TX_FULL]                          = tx_full;
        word[STAT_RX_VALID]                         = rx_valid;
        return word;
    endfunction

endpackage

// File: rtl/uart_mmio_if.sv
// Bundle of the CPU data-port bus and the uart engine byte handshake as
// seen by the memory-mapped responder. The slave modport is the
// responder's view; the master modport is the CPU/engine side.
interface uart_mmio_if;

    logic [31:0] dataaddr;
    logic [31:0] writedata;
    logic        memwrite;
    logic        memread;
    logic [31:0] readdata;

    logic [7:0]  tx_data;
    logic        tx_data_valid;
    logic        tx_data_ack;

    logic [7:0]  rx_data;
    logic        rx_data_fresh;

    modport slave (
        input  dataaddr,
        input  writedata,
        input  memwrite,
        input  memread,
        output readdata,
        output tx_data,
        output tx_data_valid,
        input  tx_data_ack,
        input  rx_data,
        input  rx_data_fresh
    );

    modport master (
        output dataaddr,
        output writedata,
        output memwrite,
        output memread,
        input  readdata,
        input  tx_data,
        input  tx_data_valid,
        output tx_data_ack,
        output rx_data,
        output rx_data_fresh
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with AW+1-bit wrapping pointers. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; a pop on
// an empty FIFO does nothing. dout reads 0 while the FIFO is empty so
// that consumers see a clean value after reset.
module uart_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [DW-1:0] mem [2**AW];
    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic          pop_ok;
    logic          push_ok;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign count   = wp - rp;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = empty ? '0 : mem[rp[AW-1:0]];

    // Pointer update; both pointers may advance in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push_ok) begin
                wp <= wp + 1'b1;
            end
            if (pop_ok) begin
                rp <= rp + 1'b1;
            end
        end
    end

    // Storage write; contents need no reset because empty masks dout.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wp[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped responder between the CPU data port and the uart serial
// engine. Stores to DATA queue bytes for transmission, loads from DATA
// pop received bytes, STATUS reports FIFO state and sticky overrun
// flags, CTRL holds the interrupt enables. The interrupt is registered.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h00021000,
    parameter int          FIFO_AW   = 4
) (
    input  logic       clk,
    input  logic       reset,
    uart_mmio_if.slave bus,
    output logic       irq
);

    logic            sel;
    uart_reg_e       reg_idx;
    logic            wr_data;
    logic            wr_status;
    logic            wr_ctrl;
    logic            rd_data;

    logic [7:0]      tx_head;
    logic            tx_full;
    logic            tx_empty;
    logic            tx_pop_ok;
    logic [FIFO_AW:0] tx_count_unused;

    logic [7:0]      rx_head;
    logic            rx_full;
    logic            rx_empty;
    logic            rx_valid;
    logic            rx_pop_ok;
    logic [FIFO_AW:0] rx_count;
    logic [7:0]      rx_count8;

    logic            tx_ovf;
    logic            rx_ovf;
    logic            tx_ovf_set;
    logic            rx_ovf_set;
    logic            rx_irq_en;
    logic            tx_irq_en;
    logic            irq_next;

    logic            addr_bits_unused;

    // Only the window base and the word index matter; byte lanes and the
    // upper write-data bits are not part of any register.
    assign addr_bits_unused = ^{bus.dataaddr[1:0], bus.writedata[31:8]};

    assign sel       = (bus.dataaddr[31:4] == BASE_ADDR[31:4]);
    assign reg_idx   = uart_reg_e'(bus.dataaddr[3:2]);
    assign wr_data   = sel && bus.memwrite && (reg_idx == UART_REG_DATA);
    assign wr_status = sel && bus.memwrite && (reg_idx == UART_REG_STATUS);
    assign wr_ctrl   = sel && bus.memwrite && (reg_idx == UART_REG_CTRL);
    assign rd_data   = sel && bus.memread  && (reg_idx == UART_REG_DATA);

    assign tx_pop_ok = bus.tx_data_ack && !tx_empty;
    assign rx_pop_ok = rd_data && !rx_empty;
    assign rx_valid  = !rx_empty;
    assign rx_count8 = 8'(rx_count);

    // A byte is lost only when the FIFO is full and nothing leaves it in
    // the same cycle.
    assign tx_ovf_set = wr_data && tx_full && !tx_pop_ok;
    assign rx_ovf_set = bus.rx_data_fresh && rx_full && !rx_pop_ok;

    uart_sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_data),
        .din   (bus.writedata[7:0]),
        .pop   (bus.tx_data_ack),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count_unused)
    );

    uart_sync_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.rx_data_fresh),
        .din   (bus.rx_data),
        .pop   (rd_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    assign bus.tx_data       = tx_head;
    assign bus.tx_data_valid = !tx_empty;

    // Sticky overrun flags: write-1-to-clear, a new overrun beats the clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_ovf <= 1'b0;
            rx_ovf <= 1'b0;
        end else begin
            if (tx_ovf_set) begin
                tx_ovf <= 1'b1;
            end else if (wr_status && bus.writedata[STAT_TX_OVF]) begin
                tx_ovf <= 1'b0;
            end
            if (rx_ovf_set) begin
                rx_ovf <= 1'b1;
            end else if (wr_status && bus.writedata[STAT_RX_OVF]) begin
                rx_ovf <= 1'b0;
            end
        end
    end

    // CTRL register holding the two interrupt enables.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_irq_en <= 1'b0;
            tx_irq_en <= 1'b0;
        end else if (wr_ctrl) begin
            rx_irq_en <= bus.writedata[CTRL_RX_IRQ_EN];
            tx_irq_en <= bus.writedata[CTRL_TX_IRQ_EN];
        end
    end

    // Combinational read mux; anything outside the window reads 0.
    always_comb begin
        bus.readdata = '0;
        if (sel) begin
            case (reg_idx)
                UART_REG_DATA:   bus.readdata = {24'b0, rx_head};
                UART_REG_STATUS: bus.readdata = pack_status(rx_count8, tx_ovf, rx_ovf,
                                                            tx_empty, tx_full, rx_valid);
                UART_REG_CTRL:   bus.readdata = {30'b0, tx_irq_en, rx_irq_en};
                default:         bus.readdata = '0;
            endcase
        end
    end

    assign irq_next = (rx_irq_en && rx_valid) || (tx_irq_en && tx_empty) || rx_ovf;

    // Interrupt request registered from the current status, one cycle behind.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_next;
        end
    end

endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio. TX and RX byte scoreboards are filled as
// bytes are offered to the design and drained as the design hands them
// back; STATUS expectations come from the scoreboard occupancy and the
// bench's own overrun flags.
module tb_uart_mmio;
    import uart_mmio_pkg::*;

    localparam logic [31:0] BASE     = 32'h00021000;
    localparam logic [31:0] A_DATA   = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'd4;
    localparam logic [31:0] A_CTRL   = BASE + 32'd8;
    localparam logic [31:0] A_RSVD   = BASE + 32'd12;
    localparam logic [31:0] A_OTHER  = 32'h00031000;
    localparam int          DEPTH    = 16;

    logic clk = 1'b0;
    logic reset;
    logic irq;

    uart_mmio_if bus_if();

    uart_mmio #(
        .BASE_ADDR (BASE),
        .FIFO_AW   (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if),
        .irq   (irq)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic       m_tx_ovf = 1'b0;
    logic       m_rx_ovf = 1'b0;
    logic [31:0] rd;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] w;
        logic [7:0]  cnt;
        cnt = 8'(rx_q.size());
        w = '0;
        w[15:8] = cnt;
        w[4]    = m_tx_ovf;
        w[3]    = m_rx_ovf;
        w[2]    = (tx_q.size() == 0);
        w[1]    = (tx_q.size() == DEPTH);
        w[0]    = (rx_q.size() != 0);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus_idle();
        bus_if.dataaddr      = A_OTHER;
        bus_if.writedata     = '0;
        bus_if.memwrite      = 1'b0;
        bus_if.memread       = 1'b0;
        bus_if.tx_data_ack   = 1'b0;
        bus_if.rx_data       = '0;
        bus_if.rx_data_fresh = 1'b0;
    endtask

    task automatic peek(input logic [31:0] addr, output logic [31:0] data);
        bus_if.dataaddr = addr;
        @(negedge clk);
        data = bus_if.readdata;
        tick();
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus_if.dataaddr  = addr;
        bus_if.writedata = data;
        bus_if.memwrite  = 1'b1;
        tick();
        bus_if.memwrite  = 1'b0;
    endtask

    task automatic bus_read_pop(input logic [31:0] addr, output logic [31:0] data);
        bus_if.dataaddr = addr;
        bus_if.memread  = 1'b1;
        @(negedge clk);
        data = bus_if.readdata;
        tick();
        bus_if.memread  = 1'b0;
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        peek(A_STATUS, d);
        check_output(tag, d, exp_status());
    endtask

    task automatic tx_store(input logic [7:0] b);
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
        else m_tx_ovf = 1'b1;
        bus_write(A_DATA, {24'h0, b});
    endtask

    task automatic tx_ack_expect(input string tag);
        logic [7:0] exp;
        exp = tx_q.pop_front();
        check_output({tag, "_valid"}, {31'b0, bus_if.tx_data_valid}, 32'd1);
        check_output({tag, "_data"}, {24'b0, bus_if.tx_data}, {24'b0, exp});
        bus_if.tx_data_ack = 1'b1;
        tick();
        bus_if.tx_data_ack = 1'b0;
    endtask

    task automatic rx_fresh(input logic [7:0] b);
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else m_rx_ovf = 1'b1;
        bus_if.rx_data       = b;
        bus_if.rx_data_fresh = 1'b1;
        tick();
        bus_if.rx_data_fresh = 1'b0;
    endtask

    task automatic rx_read_expect(input string tag);
        logic [31:0] exp;
        logic [31:0] d;
        exp = (rx_q.size() != 0) ? {24'b0, rx_q[0]} : 32'h0;
        bus_read_pop(A_DATA, d);
        if (rx_q.size() != 0) void'(rx_q.pop_front());
        check_output(tag, d, exp);
    endtask

    initial begin
        apply_stimulus_idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state.
        check_output("rst_irq", {31'b0, irq}, 32'd0);
        check_output("rst_valid", {31'b0, bus_if.tx_data_valid}, 32'd0);
        check_output("rst_txdata", {24'b0, bus_if.tx_data}, 32'd0);
        reset = 1'b1;
        tick();
        peek(A_STATUS, rd);
        check_output("rst_status", rd, 32'h00000004);
        peek(A_DATA, rd);
        check_output("rst_rxdata", rd, 32'h0);
        peek(A_RSVD, rd);
        check_output("rsvd_read", rd, 32'h0);

        // Two stores, ack one at a time.
        tx_store(8'h41);
        tx_store(8'h42);
        tx_ack_expect("tx_first");
        tx_ack_expect("tx_second");
        check_output("tx_drained_valid", {31'b0, bus_if.tx_data_valid}, 32'd0);
        check_status("tx_drained_status");

        // Overfill TX: 17th byte is dropped and flagged.
        for (int i = 0; i < DEPTH + 1; i++) tx_store(8'h10 + 8'(i));
        check_status("tx_full_status");
        peek(A_STATUS, rd);
        check_output("tx_full_const", rd, 32'h00000012);
        for (int i = 0; i < DEPTH; i++) tx_ack_expect($sformatf("tx_drain%0d", i));
        check_output("tx_after_drain_valid", {31'b0, bus_if.tx_data_valid}, 32'd0);
        bus_write(A_STATUS, 32'h10);
        m_tx_ovf = 1'b0;
        check_status("tx_ovf_cleared");

        // Writes to reserved space and other addresses change nothing.
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        bus_write(A_OTHER, 32'h0000_0055);
        check_status("ignored_writes");

        // Two received bytes, read back in order, then empty.
        rx_fresh(8'h55);
        rx_fresh(8'hAA);
        check_status("rx_two_status");
        rx_read_expect("rx_read55");
        rx_read_expect("rx_readAA");
        rx_read_expect("rx_read_empty");
        check_status("rx_empty_status");

        // Fill RX, overrun with 0x99.
        for (int i = 0; i < DEPTH; i++) rx_fresh(8'h60 + 8'(i));
        rx_fresh(8'h99);
        peek(A_STATUS, rd);
        check_output("rx_ovf_const", rd, 32'h0000100D);
        peek(A_DATA, rd);
        check_output("rx_head_kept", rd, 32'h00000060);

        // Fresh byte and pop together on a full FIFO: no overrun.
        m_rx_ovf = 1'b1;
        bus_if.dataaddr      = A_DATA;
        bus_if.memread       = 1'b1;
        bus_if.rx_data       = 8'h99;
        bus_if.rx_data_fresh = 1'b1;
        @(negedge clk);
        rd = bus_if.readdata;
        tick();
        bus_if.memread       = 1'b0;
        bus_if.rx_data_fresh = 1'b0;
        check_output("rx_simul_head", rd, {24'b0, rx_q.pop_front()});
        rx_q.push_back(8'h99);
        check_status("rx_simul_status");
        bus_write(A_STATUS, 32'h08);
        m_rx_ovf = 1'b0;
        check_status("rx_ovf_w1c");
        for (int i = 0; i < DEPTH; i++) rx_read_expect($sformatf("rx_drain%0d", i));
        check_status("rx_drained_status");

        // Interrupts.
        tick();
        bus_write(A_CTRL, 32'h1);
        peek(A_CTRL, rd);
        check_output("ctrl_readback", rd, 32'h1);
        check_output("irq_idle", {31'b0, irq}, 32'd0);
        rx_fresh(8'h77);
        check_output("irq_latency", {31'b0, irq}, 32'd0);
        tick();
        check_output("irq_rx_set", {31'b0, irq}, 32'd1);
        rx_read_expect("irq_rx_pop");
        check_output("irq_hold_after_pop", {31'b0, irq}, 32'd1);
        tick();
        check_output("irq_rx_clear", {31'b0, irq}, 32'd0);
        bus_write(A_CTRL, 32'h2);
        check_output("irq_tx_latency", {31'b0, irq}, 32'd0);
        tick();
        check_output("irq_tx_set", {31'b0, irq}, 32'd1);

        // Reset in the middle of a transfer.
        tx_store(8'hC3);
        tx_store(8'h3C);
        check_output("pre_rst_valid", {31'b0, bus_if.tx_data_valid}, 32'd1);
        reset = 1'b0;
        #1;
        tx_q.delete();
        rx_q.delete();
        check_output("midrst_valid", {31'b0, bus_if.tx_data_valid}, 32'd0);
        check_output("midrst_txdata", {24'b0, bus_if.tx_data}, 32'd0);
        check_output("midrst_irq", {31'b0, irq}, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check_output("post_rst_valid", {31'b0, bus_if.tx_data_valid}, 32'd0);
        peek(A_CTRL, rd);
        check_output("post_rst_ctrl", rd, 32'h0);
        check_status("post_rst_status");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
